// File: rtl/shift_pipe16.sv
// shift_pipe16: two-stage pipelined 16-bit shifter/rotator.
// Stage 1 applies the 1- and 2-position levels, stage 2 the 4- and 8-position
// levels, so the two stages together realise any count 0..15.
// Valid/ready handshake on both sides; flush drops everything in flight.
module shift_pipe16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // One shift level: conditionally move d by a fixed amount in the op's direction.
  // Rotates use a doubled word so the wrapped bits fall into the kept half.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             en,
    input int               amt
  );
    logic [2*WIDTH-1:0] wide_v;
    logic [WIDTH-1:0]   res_v;
    wide_v = {2*WIDTH{1'b0}};
    case (op)
      OP_ROL: begin
        wide_v = {d, d} << amt;
        res_v  = wide_v[2*WIDTH-1:WIDTH];
      end
      OP_SLL: res_v = d << amt;
      OP_ROR: begin
        wide_v = {d, d} >> amt;
        res_v  = wide_v[WIDTH-1:0];
      end
      OP_SRL: res_v = d >> amt;
      default: res_v = d;
    endcase
    if (en) begin
      return res_v;
    end else begin
      return d;
    end
  endfunction

  // Stage registers
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_data_r;
  logic [1:0]       s1_cnt_r;
  logic [1:0]       s1_op_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_data_r;
  logic [1:0]       s2_op_r;

  // Handshake and next-data signals
  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             accept_s;
  logic [WIDTH-1:0] s1_nxt_s;
  logic [WIDTH-1:0] s2_nxt_s;

  // Pipeline advance conditions: a stage moves when it is empty or its successor moves.
  always_comb begin
    s2_adv_s = !s2_valid_r | out_ready;
    s1_adv_s = !s1_valid_r | s2_adv_s;
    in_ready = s1_adv_s & !flush;
    accept_s = in_valid & in_ready;
  end

  // Low shift levels (1 and 2 positions) feeding stage 1.
  always_comb begin
    s1_nxt_s = shift_level(in_data, in_op, in_cnt[0], 1);
    s1_nxt_s = shift_level(s1_nxt_s, in_op, in_cnt[1], 2);
  end

  // High shift levels (4 and 8 positions) feeding stage 2.
  always_comb begin
    s2_nxt_s = shift_level(s1_data_r, s1_op_r, s1_cnt_r[0], 4);
    s2_nxt_s = shift_level(s2_nxt_s, s1_op_r, s1_cnt_r[1], 8);
  end

  // Stage 1 register: loads on accept, holds while stalled, cleared by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {WIDTH{1'b0}};
      s1_cnt_r   <= 2'b00;
      s1_op_r    <= 2'b00;
    end else begin
      if (flush) begin
        s1_valid_r <= 1'b0;
      end else if (s1_adv_s) begin
        s1_valid_r <= accept_s;
      end
      if (accept_s) begin
        s1_data_r <= s1_nxt_s;
        s1_cnt_r  <= in_cnt[3:2];
        s1_op_r   <= in_op;
      end
    end
  end

  // Stage 2 register: takes stage 1 contents whenever it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {WIDTH{1'b0}};
      s2_op_r    <= 2'b00;
    end else begin
      if (flush) begin
        s2_valid_r <= 1'b0;
      end else if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
      end
      if (s2_adv_s) begin
        s2_data_r <= s2_nxt_s;
        s2_op_r   <= s1_op_r;
      end
    end
  end

  // Outputs come straight from the stage 2 registers; zero flag decoded from them.
  always_comb begin
    out_valid = s2_valid_r;
    out_data  = s2_data_r;
    out_zero  = (s2_data_r == {WIDTH{1'b0}});
  end

endmodule

// File: doc/shift_pipe16.md
Name: shift_pipe16

Overview:
- Two-stage pipelined 16-bit shifter/rotator that composes the single-level shift stages into a full 4-bit-count shifter.
- Consumes the shift-by-1 and shift-by-2 level outputs, registers them, then applies the shift-by-4 and shift-by-8 levels.
- Sits between the execute-stage operand muxes and the ALU result mux.
- Valid/ready handshake on both sides so the execute stage can stall or flush it.

Parameters:
- WIDTH, 16, datapath width; the only supported value is 16.
- CNT_W, 4, shift-count width; the only supported value is 4.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous pipeline clear, active-high
- in_valid  input  1  operand/op/count valid
- in_ready  output  1  block can accept this cycle
- in_data  input  16  operand
- in_cnt  input  4  shift amount, 0..15
- in_op  input  2  00 ROL, 01 SLL, 10 ROR, 11 SRL
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  16  shifted result
- out_zero  output  1  out_data == 0, qualified by out_valid

Behaviour:
- Clock is clk (one clock). rst_n is asynchronous, active-low.
- Reset (rst_n=0, asynchronous): s1_valid=0, s2_valid=0, all data/count/op registers cleared to 0. out_valid=0 and out_data=0 immediately, without waiting for a clock edge. out_zero=1.
- Stage 1 (S1) register: captures in_data shifted by in_cnt[0] (1 position), then by in_cnt[1] (2 positions), plus in_cnt[3:2] and in_op.
- Stage 2 (S2) register: captures the S1 value shifted by cnt[2] (4 positions), then by cnt[3] (8 positions), plus op.
- out_data = S2 data register. out_zero is derived combinationally from out_data.
- Each level implements the op as follows:
  - ROL: bits wrap from MSB to LSB.
  - SLL: zero fill at LSBs.
  - ROR: bits wrap from LSB to MSB.
  - SRL: zero fill at MSBs.
- Result equals the op applied once by the full count (mod 16). cnt=0 passes data through unchanged.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv & !flush
  - Accept occurs when in_valid & in_ready.
  - S1 loads on accept; s1_valid next = accept.
  - S2 loads S1 contents when s2_adv; s2_valid next = s1_valid.
  - A stage that is not advancing holds its data and valid bits unchanged.
- Latency: exactly 2 cycles from accept edge to out_valid when not stalled. Full throughput: 1 result per cycle with out_ready held high.
- Ordering: results emerge in acceptance order. No loss or duplication under any out_ready pattern.
- Backpressure: out_ready=0 with both stages valid → in_ready=0 and all registers hold.
- Out-of-order consumption: out_ready=1 while out_valid=0 is harmless.
- Simultaneous out_ready and a full pipe: both stages advance in the same cycle, and a new input is accepted that cycle.
- flush=1 at a clock edge:
  - s1_valid and s2_valid are cleared; data registers may keep stale values.
  - in_ready is 0 for that cycle, so nothing is accepted; flush wins over in_valid.
  - out_valid is 0 on the next cycle.
- The consumer must not rely on out_data when out_valid=0.
- in_data, in_cnt and in_op are sampled only on accept. in_valid may drop without a transfer.

Test Plan:
- Latency/ROL: reset, then accept ROL 16'h8001 cnt=1 with out_ready=1 → out_valid=1 and out_data=16'h0003 exactly 2 cycles later. out_zero=0.
- Op/count sweep: SLL 16'h00FF cnt=4 → 16'h0FF0; SRL 16'hF000 cnt=15 → 16'h0001; ROR 16'h0001 cnt=1 → 16'h8000; ROL 16'h1234 cnt=0 → 16'h1234; SLL 16'h8000 cnt=1 → 16'h0000 with out_zero=1. Also run a random 2000-op sweep against a behavioural model.
- Throughput: 4 back-to-back accepts (SLL 16'h0001 cnt=0..3) with out_ready=1 → results 0001, 0002, 0004, 0008 on 4 consecutive cycles. in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 and offer 3 inputs → 2 accepted, then in_ready=0. out_data holds the first result stable. Releasing out_ready drains the results in order and accepts the 3rd; no duplicates.
- Flush: both stages valid, flush=1 with in_valid=1 → in_ready=0 that cycle and out_valid=0 next cycle. The next accept afterwards produces a correct result 2 cycles later.
- Async reset: pulse rst_n low mid-cycle with the pipe full → out_valid and out_data go to 0 before the next clock edge. After release, the first accepted op returns correctly after 2 cycles.
